synapse_accumulator: RTL and testbench

- Sequential multiply-accumulate stage that sits directly upstream of the neuron stage.
- Accepts one vector of NP parent activations per transaction and combines it with an NP×NC weight array.
- Serially over NP cycles, forms NC signed weighted sums; each sum is sized to the neuron's per-lane input width, clog2(NP)+1+WD.
- Presents the NC sums on a valid/ready output that connects directly to the neuron's _AS input.

---
 rtl/synapse_accumulator_pkg.sv | 16 +
 rtl/synapse_mac_lane.sv | 55 +++++
 rtl/synapse_accumulator.sv | 122 ++++++++++++
 tb/tb_synapse_accumulator.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synapse_accumulator_pkg.sv
// Shared definitions for the synapse accumulator and the neuron stage it feeds:
// lane-sum width and the controller state encoding.
package synapse_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        HOLD = 2'b10
    } state_e;

    // Width of one signed lane sum: NP terms of a 1+WD-bit signed product.
    function automatic int lane_width(input int np, input int wd);
        return $clog2(np) + 1 + wd;
    endfunction

endpackage

// File: rtl/synapse_mac_lane.sv
// One child lane: unsigned activation times signed weight, floored by 2^WD,
// accumulated into a signed register with synchronous clear and enable.
module synapse_mac_lane
    import synapse_accumulator_pkg::*;
#(
    parameter int NP = 4,
    parameter int WD = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clr_i,
    input  logic                                   en_i,
    input  logic [WD-1:0]                          act_i,
    input  logic signed [WD:0]                     wgt_i,
    output logic signed [lane_width(NP, WD)-1:0]   acc_o
);

    localparam int SW = lane_width(NP, WD);
    localparam int PW = 2 * WD + 2;

    logic signed [PW-1:0] prod_s;
    logic signed [SW-1:0] term_s;
    logic signed [SW-1:0] acc_d;
    logic signed [SW-1:0] acc_q;

    // Full-precision product, arithmetic shift floors toward -inf, then resize to lane width.
    always_comb begin
        prod_s = $signed({{(WD + 2){1'b0}}, act_i}) * $signed({{(WD + 1){wgt_i[WD]}}, wgt_i});
        term_s = SW'(prod_s >>> WD);
    end

    // Next accumulator value: clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + term_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/synapse_accumulator.sv
// Serial multiply-accumulate stage: captures NP activations and NP x NC weights,
// accumulates over NP cycles, then holds NC signed sums on a valid/ready output.
module synapse_accumulator
    import synapse_accumulator_pkg::*;
#(
    parameter int NP = 4,
    parameter int NC = 4,
    parameter int WD = 4
) (
    input  logic                                  iCLK,
    input  logic                                  iRST,
    input  logic                                  iValid_AS,
    output logic                                  oReady_AS,
    input  logic [NP*WD-1:0]                      iData_AS,
    input  logic [NP*NC*(1+WD)-1:0]               iWeight,
    output logic                                  oValid_BS,
    input  logic                                  iReady_BS,
    output logic [NC*lane_width(NP, WD)-1:0]      oData_BS
);

    localparam int SW = lane_width(NP, WD);
    localparam int CW = $clog2(NP);

    state_e              state_q;
    state_e              state_d;
    logic [CW-1:0]       k_q;
    logic [CW-1:0]       k_d;
    logic                clr_s;
    logic                en_s;
    logic [WD-1:0]       act_q [NP];
    logic signed [WD:0]  wgt_q [NP][NC];
    logic signed [SW-1:0] acc_s [NC];

    // Controller next state, counter and lane strobes.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        clr_s   = 1'b0;
        en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iValid_AS) begin
                    state_d = ACC;
                    k_d     = '0;
                    clr_s   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                en_s = 1'b1;
                if (k_q == CW'(NP - 1)) begin
                    state_d = HOLD;
                    k_d     = '0;
                end else begin
                    k_d = k_q + CW'(1'b1);
                end
            end
            HOLD: begin
                if (iReady_BS) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Operands are sampled only at acceptance, so later input changes are ignored.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            for (int k = 0; k < NP; k++) begin
                act_q[k] <= '0;
                for (int c = 0; c < NC; c++) begin
                    wgt_q[k][c] <= '0;
                end
            end
        end else if (clr_s) begin
            for (int k = 0; k < NP; k++) begin
                act_q[k] <= iData_AS[k*WD +: WD];
                for (int c = 0; c < NC; c++) begin
                    wgt_q[k][c] <= $signed(iWeight[(k*NC + c)*(WD + 1) +: (WD + 1)]);
                end
            end
        end
    end

    for (genvar c = 0; c < NC; c++) begin : g_lane
        synapse_mac_lane #(
            .NP (NP),
            .WD (WD)
        ) u_lane (
            .clk_i  (iCLK),
            .rst_ni (iRST),
            .clr_i  (clr_s),
            .en_i   (en_s),
            .act_i  (act_q[k_q]),
            .wgt_i  (wgt_q[k_q][c]),
            .acc_o  (acc_s[c])
        );
        assign oData_BS[c*SW +: SW] = acc_s[c];
    end

    assign oReady_AS = (state_q == IDLE);
    assign oValid_BS = (state_q == HOLD);

endmodule

// File: tb/tb_synapse_accumulator.sv
// Randomised and directed bench for synapse_accumulator (NP=4, NC=2, WD=4) with a
// queue scoreboard fed at acceptance and drained by an independent output monitor.
module tb_synapse_accumulator;

    localparam int NP = 4;
    localparam int NC = 2;
    localparam int WD = 4;
    localparam int SW = 7;
    localparam int DW = NP * WD;
    localparam int WW = NP * NC * (WD + 1);
    localparam int OW = NC * SW;

    logic          iCLK;
    logic          iRST;
    logic          iValid_AS;
    logic          oReady_AS;
    logic [DW-1:0] iData_AS;
    logic [WW-1:0] iWeight;
    logic          oValid_BS;
    logic          iReady_BS;
    logic [OW-1:0] oData_BS;

    int            n_checks;
    int            n_fail;
    int            cyc;
    int            rdy_mode;
    logic [OW-1:0] exp_q [$];
    int            acc_cyc_q [$];

    synapse_accumulator #(
        .NP (NP),
        .NC (NC),
        .WD (WD)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iValid_AS (iValid_AS),
        .oReady_AS (oReady_AS),
        .iData_AS  (iData_AS),
        .iWeight   (iWeight),
        .oValid_BS (oValid_BS),
        .iReady_BS (iReady_BS),
        .oData_BS  (oData_BS)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: each lane is the sum over k of floor(a_k * w_kc / 2^WD).
    function automatic logic [OW-1:0] model(input logic [DW-1:0] d, input logic [WW-1:0] w);
        logic [OW-1:0] r;
        logic [4:0]    wb;
        int            a, wv, p, q, sum;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            sum = 0;
            for (int k = 0; k < NP; k++) begin
                a  = int'(d[k*WD +: WD]);
                wb = w[(k*NC + c)*(WD + 1) +: (WD + 1)];
                wv = (wb >= 5'd16) ? int'(wb) - 32 : int'(wb);
                p  = a * wv;
                q  = (p >= 0) ? p / 16 : -((-p + 15) / 16);
                sum += q;
            end
            r[c*SW +: SW] = sum[SW-1:0];
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] uniform_w(input logic [4:0] w0, input logic [4:0] w1);
        logic [WW-1:0] r;
        r = '0;
        for (int k = 0; k < NP; k++) begin
            r[(k*NC + 0)*5 +: 5] = w0;
            r[(k*NC + 1)*5 +: 5] = w1;
        end
        return r;
    endfunction

    // Ready driver: 0 = held high, 1 = random, otherwise held low.
    initial begin
        iReady_BS = 1'b1;
        forever begin
            @(posedge iCLK);
            #1;
            case (rdy_mode)
                0:       iReady_BS = 1'b1;
                1:       iReady_BS = 1'($urandom_range(0, 1));
                default: iReady_BS = 1'b0;
            endcase
        end
    end

    // Monitor: latency on valid rise, hold-state ready, and scoreboard on output handshake.
    initial begin
        logic          prev_v;
        logic [OW-1:0] e;
        int            t;
        prev_v = 1'b0;
        forever begin
            @(negedge iCLK);
            if (oValid_BS && !prev_v) begin
                if (acc_cyc_q.size() > 0) begin
                    t = acc_cyc_q.pop_front();
                    check("latency", cyc - t, NP + 1);
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL orphan_valid: output valid with no accepted vector at cycle %0d", cyc);
                end
            end
            if (oValid_BS) check("ready_in_hold", oReady_AS, 0);
            if (oValid_BS && iReady_BS) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sum", oData_BS, e);
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", oData_BS);
                end
            end
            prev_v = oValid_BS;
        end
    end

    // Drive a vector (caller is just past a rising edge); returns just after the acceptance edge.
    task automatic send(input logic [DW-1:0] d, input logic [WW-1:0] w, input bit keep, output int acc_cyc);
        bit done;
        done     = 1'b0;
        acc_cyc  = -1;
        iData_AS = d;
        iWeight  = w;
        iValid_AS = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge iCLK);
            if (oReady_AS) begin
                done    = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back(model(d, w));
                acc_cyc_q.push_back(cyc);
            end
            @(posedge iCLK);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: vector not accepted within 60 cycles");
        end
        if (!keep) iValid_AS = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge iCLK);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d outputs still pending", exp_q.size());
        end
    endtask

    initial begin
        logic [DW-1:0] d1;
        logic [WW-1:0] w1;
        logic [DW-1:0] rd;
        logic [WW-1:0] rw;
        logic [OW-1:0] e1;
        int            ac;
        int            ac_b [3];
        bit            seen;

        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rdy_mode  = 0;
        iRST      = 1'b0;
        iValid_AS = 1'b0;
        iData_AS  = '0;
        iWeight   = '0;
        d1 = {4'd4, 4'd3, 4'd2, 4'd1};
        w1 = uniform_w(5'd15, 5'b10000);
        e1 = {7'b1110110, 7'd6};

        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b1;
        @(negedge iCLK);
        check("reset_ready", oReady_AS, 1);
        check("reset_valid", oValid_BS, 0);
        check("reset_data", oData_BS, 0);

        // Scenarios 1 and 3: known sums, then 5 stalled cycles with stable output.
        rdy_mode = 2;
        @(posedge iCLK);
        #1;
        send(d1, w1, 1'b0, ac);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge iCLK);
            if (oValid_BS) seen = 1'b1;
        end
        check("s1_valid_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge iCLK);
            check("stall_data", oData_BS, e1);
            check("stall_valid", oValid_BS, 1);
            check("stall_ready", oReady_AS, 0);
        end
        rdy_mode = 0;
        @(negedge iCLK);
        @(negedge iCLK);
        check("ready_after_handshake", oReady_AS, 1);
        check("valid_after_handshake", oValid_BS, 0);

        // Scenario 2: maximum-magnitude operands.
        @(posedge iCLK);
        #1;
        send({4'd15, 4'd15, 4'd15, 4'd15}, uniform_w(5'd15, 5'b10000), 1'b0, ac);
        drain();

        // Scenario 4: reset during the second accumulate cycle aborts the vector.
        @(posedge iCLK);
        #1;
        send(d1, w1, 1'b0, ac);
        @(posedge iCLK);
        #1 iRST = 1'b0;
        @(posedge iCLK);
        #1 iRST = 1'b1;
        exp_q.delete();
        acc_cyc_q.delete();
        @(negedge iCLK);
        check("abort_valid", oValid_BS, 0);
        check("abort_ready", oReady_AS, 1);
        @(posedge iCLK);
        #1;
        send(d1, w1, 1'b0, ac);
        drain();

        // Scenario 5: inputs cleared right after acceptance do not affect the result.
        @(posedge iCLK);
        #1;
        send(d1, w1, 1'b0, ac);
        iData_AS = '0;
        iWeight  = '0;
        drain();

        // Scenario 6: back-to-back vectors with valid and ready held high.
        @(posedge iCLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            rd = DW'($urandom);
            rw = {$urandom, $urandom};
            send(rd, rw, (i < 2), ac_b[i]);
        end
        check("b2b_spacing_1", ac_b[1] - ac_b[0], NP + 2);
        check("b2b_spacing_2", ac_b[2] - ac_b[1], NP + 2);
        drain();

        // Random vectors with random downstream back-pressure and idle gaps.
        rdy_mode = 1;
        @(posedge iCLK);
        #1;
        for (int i = 0; i < 40; i++) begin
            rd = DW'($urandom);
            rw = {$urandom, $urandom};
            send(rd, rw, 1'b0, ac);
            repeat ($urandom_range(0, 2)) begin
                @(posedge iCLK);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
